// File: rtl/cpu_ctrl_v2_if.sv
// Instruction handshake and datapath strobe bundle for cpu_ctrl_v2.
// The master modport is the controller; the slave modport is the datapath/fetch side.
interface cpu_ctrl_v2_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REG_COUNT = 8
);
    logic                 run;
    logic                 inst_valid;
    logic                 inst_ready;
    logic [15:0]          d_inst;
    logic                 ls_done;
    logic [2:0]           flags;
    logic [3:0]           mux_sel;
    logic [2:0]           sel;
    logic                 en_s;
    logic                 en_c;
    logic                 sel_reg_c;
    logic [1:0]           en_ls;
    logic [REG_COUNT-1:0] en;
    logic [DATA_W-1:0]    im_d;
    logic [DATA_W-1:0]    br_off;
    logic                 pc_inc;
    logic                 pc_load;
    logic                 done;
    logic                 err;

    modport master (
        input  run, inst_valid, d_inst, ls_done, flags,
        output inst_ready, mux_sel, sel, en_s, en_c, sel_reg_c, en_ls, en,
               im_d, br_off, pc_inc, pc_load, done, err
    );

    modport slave (
        output run, inst_valid, d_inst, ls_done, flags,
        input  inst_ready, mux_sel, sel, en_s, en_c, sel_reg_c, en_ls, en,
               im_d, br_off, pc_inc, pc_load, done, err
    );
endinterface

// File: rtl/cpu_ctrl_v2.sv
// Second-generation bitty control sequencer: latches one instruction per
// handshake and steps the datapath strobes through OP1/EXEC/LSW/BR/WB.
module cpu_ctrl_v2 #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned REG_COUNT    = 8,
    parameter int unsigned SIGN_EXT_IMM = 0,
    parameter int unsigned LS_TIMEOUT   = 255
) (
    input logic           clk,
    input logic           reset,
    cpu_ctrl_v2_if.master bus
);
    // Counter only has to reach LS_TIMEOUT-1 before the timeout fires.
    localparam int unsigned CNT_W = (LS_TIMEOUT < 2) ? 1 : $clog2(LS_TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((LS_TIMEOUT == 0) ? 0 : LS_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, OP1, EXEC, LSW, BR, WB} state_t;

    state_t           state, state_nx;
    logic [15:0]      ir;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             fault, fault_nx;

    logic [1:0] fmt;
    logic [2:0] rd, rs, op;
    logic       ls_flag;
    logic [7:0] imm8;
    logic       illegal;
    logic       taken;

    assign fmt     = ir[1:0];
    assign rd      = ir[15:13];
    assign rs      = ir[12:10];
    assign op      = ir[4:2];
    assign ls_flag = ir[2];
    assign imm8    = ir[12:5];

    assign illegal = (32'(rd) >= REG_COUNT) || ((fmt != 2'b01) && (32'(rs) >= REG_COUNT));

    always_comb begin
        if (SIGN_EXT_IMM != 0)
            bus.im_d = {{(DATA_W-8){imm8[7]}}, imm8};
        else
            bus.im_d = {{(DATA_W-8){1'b0}}, imm8};
        bus.br_off = {{(DATA_W-8){imm8[7]}}, imm8};
    end

    // flags = {carry, neg, zero}
    always_comb begin
        case (rd)
            3'd0:    taken = 1'b1;
            3'd1:    taken = bus.flags[0];
            3'd2:    taken = !bus.flags[0];
            3'd3:    taken = bus.flags[1];
            3'd4:    taken = !bus.flags[1];
            3'd5:    taken = bus.flags[2];
            3'd6:    taken = !bus.flags[2];
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ir    <= '0;
            cnt   <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            fault <= fault_nx;
            if (state == IDLE && bus.run && bus.inst_valid)
                ir <= bus.d_inst;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        fault_nx      = fault;
        bus.inst_ready = 1'b0;
        bus.mux_sel   = 4'b1001;
        bus.sel       = '0;
        bus.en_s      = 1'b0;
        bus.en_c      = 1'b0;
        bus.sel_reg_c = 1'b0;
        bus.en_ls     = 2'b00;
        bus.en        = '0;
        bus.pc_inc    = 1'b0;
        bus.pc_load   = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        case (state)
            IDLE: begin
                bus.inst_ready = 1'b1;
                fault_nx       = 1'b0;
                if (bus.run && bus.inst_valid)
                    state_nx = (bus.d_inst[1:0] == 2'b10) ? BR : OP1;
            end
            OP1: begin
                bus.mux_sel = {1'b0, rd};
                if (illegal) begin
                    fault_nx = 1'b1;
                    state_nx = WB;
                end else begin
                    bus.en_s = 1'b1;
                    state_nx = (fmt == 2'b11) ? LSW : EXEC;
                end
            end
            EXEC: begin
                bus.mux_sel = (fmt == 2'b00) ? {1'b0, rs} : 4'b1000;
                bus.sel     = op;
                bus.en_c    = 1'b1;
                state_nx    = WB;
            end
            LSW: begin
                bus.mux_sel   = {1'b0, rs};
                bus.en_ls     = ls_flag ? 2'b10 : 2'b01;
                bus.sel_reg_c = 1'b1;
                cnt_nx        = cnt + 1'b1;
                // ls_done takes priority over a coinciding timeout
                if (bus.ls_done) begin
                    bus.en_c = 1'b1;
                    state_nx = WB;
                end else if (LS_TIMEOUT != 0 && cnt == TMO_LAST) begin
                    fault_nx = 1'b1;
                    state_nx = WB;
                end
            end
            BR: begin
                bus.pc_load = taken;
                bus.pc_inc  = !taken;
                bus.done    = 1'b1;
                state_nx    = IDLE;
            end
            WB: begin
                bus.done   = 1'b1;
                bus.pc_inc = 1'b1;
                bus.err    = fault;
                if (!fault && !(fmt == 2'b11 && ls_flag))
                    for (int unsigned i = 0; i < REG_COUNT; i++)
                        bus.en[i] = (32'(rd) == i);
                cnt_nx   = '0;
                fault_nx = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpu_ctrl_v2.sv
// Directed per-cycle vector bench for cpu_ctrl_v2: dut_a uses defaults,
// dut_b uses REG_COUNT=4, SIGN_EXT_IMM=1, LS_TIMEOUT=3.
module tb_cpu_ctrl_v2;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    cpu_ctrl_v2_if #(.DATA_W(16), .REG_COUNT(8)) ia ();
    cpu_ctrl_v2_if #(.DATA_W(16), .REG_COUNT(4)) ib ();

    cpu_ctrl_v2 #(.DATA_W(16), .REG_COUNT(8), .SIGN_EXT_IMM(0), .LS_TIMEOUT(255))
        dut_a (.clk(clk), .reset(rst_a), .bus(ia));
    cpu_ctrl_v2 #(.DATA_W(16), .REG_COUNT(4), .SIGN_EXT_IMM(1), .LS_TIMEOUT(3))
        dut_b (.clk(clk), .reset(rst_b), .bus(ib));

    // ctl = {inst_ready, en_s, en_c, sel_reg_c, en_ls[1:0], pc_inc, pc_load, done, err}
    localparam logic [9:0] IDL  = 10'b1_000_00_0000;
    localparam logic [9:0] OP   = 10'b0_100_00_0000;
    localparam logic [9:0] OPX  = 10'b0_000_00_0000;
    localparam logic [9:0] EXE  = 10'b0_010_00_0000;
    localparam logic [9:0] LDW  = 10'b0_001_01_0000;
    localparam logic [9:0] LDC  = 10'b0_011_01_0000;
    localparam logic [9:0] STC  = 10'b0_011_10_0000;
    localparam logic [9:0] WBK  = 10'b0_000_00_1010;
    localparam logic [9:0] WBE  = 10'b0_000_00_1011;
    localparam logic [9:0] BRT  = 10'b0_000_00_0110;
    localparam logic [9:0] BRN  = 10'b0_000_00_1010;

    typedef struct {
        bit          b;
        bit          rst;
        bit          run;
        bit          vld;
        logic [15:0] inst;
        bit          lsd;
        logic [2:0]  fl;
        logic [9:0]  ctl;
        logic [3:0]  mux;
        logic [2:0]  sel;
        logic [7:0]  en;
        logic [15:0] imd;
        logic [15:0] bro;
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic add(input bit b, input bit rst, input bit run, input bit vld,
                       input logic [15:0] inst, input bit lsd, input logic [2:0] fl,
                       input logic [9:0] ctl, input logic [3:0] mux, input logic [2:0] sel,
                       input logic [7:0] en, input logic [15:0] imd, input logic [15:0] bro);
        vec_t v;
        v.b = b; v.rst = rst; v.run = run; v.vld = vld; v.inst = inst; v.lsd = lsd;
        v.fl = fl; v.ctl = ctl; v.mux = mux; v.sel = sel; v.en = en; v.imd = imd; v.bro = bro;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        rst_a = 1'b0; rst_b = 1'b0;
        ia.run = 1'b0; ia.inst_valid = 1'b0; ia.d_inst = '0; ia.ls_done = 1'b0; ia.flags = '0;
        ib.run = 1'b0; ib.inst_valid = 1'b0; ib.d_inst = '0; ib.ls_done = 1'b0; ib.flags = '0;
    endtask

    task automatic drive(input vec_t v);
        idle_inputs();
        if (!v.b) begin
            rst_a = v.rst; ia.run = v.run; ia.inst_valid = v.vld; ia.d_inst = v.inst;
            ia.ls_done = v.lsd; ia.flags = v.fl;
        end else begin
            rst_b = v.rst; ib.run = v.run; ib.inst_valid = v.vld; ib.d_inst = v.inst;
            ib.ls_done = v.lsd; ib.flags = v.fl;
        end
    endtask

    task automatic check(input vec_t v, input int idx);
        logic [9:0]  a_ctl;
        logic [3:0]  a_mux;
        logic [2:0]  a_sel;
        logic [7:0]  a_en;
        logic [15:0] a_imd, a_bro;
        if (!v.b) begin
            a_ctl = {ia.inst_ready, ia.en_s, ia.en_c, ia.sel_reg_c, ia.en_ls,
                     ia.pc_inc, ia.pc_load, ia.done, ia.err};
            a_mux = ia.mux_sel; a_sel = ia.sel; a_en = ia.en; a_imd = ia.im_d; a_bro = ia.br_off;
        end else begin
            a_ctl = {ib.inst_ready, ib.en_s, ib.en_c, ib.sel_reg_c, ib.en_ls,
                     ib.pc_inc, ib.pc_load, ib.done, ib.err};
            a_mux = ib.mux_sel; a_sel = ib.sel; a_en = {4'b0000, ib.en};
            a_imd = ib.im_d; a_bro = ib.br_off;
        end
        nvec++;
        if ({a_ctl, a_mux, a_sel, a_en, a_imd, a_bro} !== {v.ctl, v.mux, v.sel, v.en, v.imd, v.bro}) begin
            nerr++;
            $display("FAIL vec%0d dut_%s: got ctl=%b mux=%b sel=%b en=%b im_d=%h br_off=%h, want ctl=%b mux=%b sel=%b en=%b im_d=%h br_off=%h",
                     idx, v.b ? "b" : "a", a_ctl, a_mux, a_sel, a_en, a_imd, a_bro,
                     v.ctl, v.mux, v.sel, v.en, v.imd, v.bro);
        end
    endtask

    initial begin
        int lat;

        // dut_a: reset state, reg-reg ALU with inst_valid ignored mid-instruction
        add(0,0,0,0,16'h0000,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h0000,16'h0000);
        add(0,0,1,1,16'h540C,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h0000,16'h0000);
        add(0,0,1,1,16'hFFFF,0,3'b000, OP ,4'h2,3'd0,8'h00,16'h00A0,16'hFFA0);
        add(0,0,1,0,16'h0000,0,3'b000, EXE,4'h5,3'd3,8'h00,16'h00A0,16'hFFA0);
        add(0,0,1,0,16'h0000,0,3'b000, WBK,4'h9,3'd0,8'h04,16'h00A0,16'hFFA0);
        // reg-imm, accepted the cycle after done, zero-extended immediate
        add(0,0,1,1,16'h7E15,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h00A0,16'hFFA0);
        add(0,0,1,0,16'h0000,0,3'b000, OP ,4'h3,3'd0,8'h00,16'h00F0,16'hFFF0);
        add(0,0,1,0,16'h0000,0,3'b000, EXE,4'h8,3'd5,8'h00,16'h00F0,16'hFFF0);
        add(0,0,1,0,16'h0000,0,3'b000, WBK,4'h9,3'd0,8'h08,16'h00F0,16'hFFF0);
        // branches: Z taken, Z not taken, N taken
        add(0,0,1,1,16'h3FC2,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h00F0,16'hFFF0);
        add(0,0,1,0,16'h0000,0,3'b001, BRT,4'h9,3'd0,8'h00,16'h00FE,16'hFFFE);
        add(0,0,1,1,16'h3FC2,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h00FE,16'hFFFE);
        add(0,0,1,0,16'h0000,0,3'b110, BRN,4'h9,3'd0,8'h00,16'h00FE,16'hFFFE);
        add(0,0,1,1,16'h7FC2,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h00FE,16'hFFFE);
        add(0,0,1,0,16'h0000,0,3'b010, BRT,4'h9,3'd0,8'h00,16'h00FE,16'hFFFE);
        // load rd=1, ls_done on 4th LSW cycle; stray ls_done in OP1
        add(0,0,1,1,16'h2803,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h00FE,16'hFFFE);
        add(0,0,1,0,16'h0000,1,3'b000, OP ,4'h1,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,1,0,16'h0000,0,3'b000, LDW,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,1,0,16'h0000,0,3'b000, LDW,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,1,0,16'h0000,0,3'b000, LDW,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,1,0,16'h0000,1,3'b000, LDC,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,1,0,16'h0000,0,3'b000, WBK,4'h9,3'd0,8'h02,16'h0040,16'h0040);
        // store, ls_done on first LSW cycle
        add(0,0,1,1,16'h2807,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,1,0,16'h0000,0,3'b000, OP ,4'h1,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,1,0,16'h0000,1,3'b000, STC,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,1,0,16'h0000,0,3'b000, WBK,4'h9,3'd0,8'h00,16'h0040,16'h0040);
        // reset during LSW aborts the load
        add(0,0,1,1,16'h2803,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,1,0,16'h0000,0,3'b000, OP ,4'h1,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,1,0,16'h0000,0,3'b000, LDW,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(0,1,0,0,16'h0000,0,3'b000, LDW,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(0,0,0,0,16'h0000,1,3'b000, IDL,4'h9,3'd0,8'h00,16'h0000,16'h0000);
        add(0,0,0,0,16'h0000,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h0000,16'h0000);
        // dut_b: reg-imm with sign-extended immediate
        add(1,0,1,1,16'h7E15,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h0000,16'h0000);
        add(1,0,1,0,16'h0000,0,3'b000, OP ,4'h3,3'd0,8'h00,16'hFFF0,16'hFFF0);
        add(1,0,1,0,16'h0000,0,3'b000, EXE,4'h8,3'd5,8'h00,16'hFFF0,16'hFFF0);
        add(1,0,1,0,16'h0000,0,3'b000, WBK,4'h9,3'd0,8'h08,16'hFFF0,16'hFFF0);
        // load timeout after 3 cycles, then ls_done exactly on 3rd cycle
        add(1,0,1,1,16'h2803,0,3'b000, IDL,4'h9,3'd0,8'h00,16'hFFF0,16'hFFF0);
        add(1,0,1,0,16'h0000,0,3'b000, OP ,4'h1,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,0,16'h0000,0,3'b000, LDW,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,0,16'h0000,0,3'b000, LDW,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,0,16'h0000,0,3'b000, LDW,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,0,16'h0000,0,3'b000, WBE,4'h9,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,1,16'h2803,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,0,16'h0000,0,3'b000, OP ,4'h1,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,0,16'h0000,0,3'b000, LDW,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,0,16'h0000,0,3'b000, LDW,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,0,16'h0000,1,3'b000, LDC,4'h2,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,0,16'h0000,0,3'b000, WBK,4'h9,3'd0,8'h02,16'h0040,16'h0040);
        // illegal rd=6, illegal rs=5 (fmt 00), legal rs field in fmt 01
        add(1,0,1,1,16'hC408,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h0040,16'h0040);
        add(1,0,1,0,16'h0000,0,3'b000, OPX,4'h6,3'd0,8'h00,16'h0020,16'h0020);
        add(1,0,1,0,16'h0000,0,3'b000, WBE,4'h9,3'd0,8'h00,16'h0020,16'h0020);
        add(1,0,1,1,16'h3400,0,3'b000, IDL,4'h9,3'd0,8'h00,16'h0020,16'h0020);
        add(1,0,1,0,16'h0000,0,3'b000, OPX,4'h1,3'd0,8'h00,16'hFFA0,16'hFFA0);
        add(1,0,1,0,16'h0000,0,3'b000, WBE,4'h9,3'd0,8'h00,16'hFFA0,16'hFFA0);
        add(1,0,1,1,16'h3401,0,3'b000, IDL,4'h9,3'd0,8'h00,16'hFFA0,16'hFFA0);
        add(1,0,1,0,16'h0000,0,3'b000, OP ,4'h1,3'd0,8'h00,16'hFFA0,16'hFFA0);
        add(1,0,1,0,16'h0000,0,3'b000, EXE,4'h8,3'd0,8'h00,16'hFFA0,16'hFFA0);
        add(1,0,1,0,16'h0000,0,3'b000, WBK,4'h9,3'd0,8'h02,16'hFFA0,16'hFFA0);
        add(1,0,0,0,16'h0000,0,3'b000, IDL,4'h9,3'd0,8'h00,16'hFFA0,16'hFFA0);

        idle_inputs();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            drive(vq[i]);
            #4;
            check(vq[i], i);
        end

        // Dropping run after accept must not abort; done expected 3 cycles later.
        @(posedge clk);
        #1;
        idle_inputs();
        ia.run = 1'b1; ia.inst_valid = 1'b1; ia.d_inst = 16'h540C;
        @(posedge clk);
        #1;
        ia.run = 1'b0; ia.d_inst = 16'h7E15;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            #4;
            if (ia.done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        nvec++;
        if (lat != 3 || ia.en !== 8'h04) begin
            nerr++;
            $display("FAIL run_drop: got done latency=%0d en=%b, want latency=3 en=00000100", lat, ia.en);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #5;
            nvec++;
            if (ia.inst_ready !== 1'b1 || ia.en_s !== 1'b0 || ia.mux_sel !== 4'b1001) begin
                nerr++;
                $display("FAIL run_low_block%0d: got inst_ready=%b en_s=%b mux_sel=%b, want 1 0 1001",
                         c, ia.inst_ready, ia.en_s, ia.mux_sel);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl_v2.md
Name: cpu_ctrl_v2

Overview:
- Parametrised second-generation control sequencer for the bitty core.
- Accepts one 16-bit instruction per handshake, latches it, and sequences the datapath strobes: S/C register enables, operand mux, ALU select, register-file write enables and load/store enable.
- New relative to the first-generation controller: instruction latching with a valid/ready handshake, a parametrised register count, conditional branch resolution with PC control, a load/store timeout, and illegal-register detection.

Parameters:
- DATA_W, 16, datapath width; width of im_d and br_off.
- REG_COUNT, 8, number of architectural registers (2..8); width of en.
- SIGN_EXT_IMM, 0, 1 = 8-bit immediate is sign-extended into im_d; 0 = zero-extended.
- LS_TIMEOUT, 255, maximum cycles to wait for ls_done; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  permits accepting a new instruction.
- inst_valid  in  1  d_inst is valid.
- inst_ready  out  1  controller can accept an instruction (high only in IDLE).
- d_inst  in  16  instruction.
- ls_done  in  1  load/store unit completion.
- flags  in  3  {carry, neg, zero} from the ALU.
- mux_sel  out  4  operand mux select: {0,idx} = register idx, 1000 = immediate, 1001 = idle default.
- sel  out  3  ALU operation.
- en_s  out  1  S register load.
- en_c  out  1  C register load.
- sel_reg_c  out  1  C register takes the LSU result.
- en_ls  out  2  01 = load, 10 = store, 00 = none.
- en  out  REG_COUNT  one-hot register-file write enable.
- im_d  out  DATA_W  immediate value.
- br_off  out  DATA_W  sign-extended branch offset.
- pc_inc  out  1  advance PC.
- pc_load  out  1  PC += br_off.
- done  out  1  instruction retired (one-cycle pulse).
- err  out  1  retired instruction faulted (asserted together with done).

Behaviour:
- **Instruction fields** (taken from the latched copy ir, never from d_inst after accept):
  - fmt = ir[1:0]; rd = ir[15:13]; rs = ir[12:10]; op = ir[4:2]; ls_flag = ir[2]; imm8 = ir[12:5].
- **Formats:** 00 reg-reg ALU; 01 reg-imm ALU; 10 branch; 11 load/store (ls_flag 0 = load, 1 = store).
- **Reset (synchronous, active-high):** state IDLE, ir = 0, timeout counter = 0. All outputs take their idle values: mux_sel = 1001, im_d = 0, br_off = 0, and every other output 0 except inst_ready = 1. Reset mid-instruction aborts it: no write, no done, en_ls drops the next cycle.
- **im_d / br_off:** combinational from ir.
  - im_d = imm8 zero- or sign-extended per SIGN_EXT_IMM.
  - br_off = imm8 always sign-extended.
- **IDLE**
  - inst_ready = 1.
  - Accept occurs when run & inst_valid: ir <= d_inst.
  - Go to BR if fmt = 10, otherwise OP1.
  - While not in IDLE, inst_valid is ignored and inst_ready = 0.
- **Illegal register check** (applies in OP1, formats 00/01/11):
  - The check fails if rd >= REG_COUNT, or rs >= REG_COUNT for fmt 00/11.
  - On failure go to WB with a fault pending: no en_s, no en_ls.
- **OP1** (1 cycle)
  - en_s = 1, mux_sel = {0,rd}.
  - Go to EXEC (fmt 00/01) or LSW (fmt 11).
- **EXEC** (1 cycle)
  - mux_sel = {0,rs} for fmt 00, 1000 for fmt 01; sel = op; en_c = 1.
  - Go to WB.
- **LSW**
  - mux_sel = {0,rs}; en_ls held at 01/10 every cycle; sel_reg_c = 1; the counter increments each cycle.
  - en_c = 1 only in the cycle ls_done = 1; that same cycle go to WB.
  - If LS_TIMEOUT != 0 and the counter reaches LS_TIMEOUT with ls_done = 0, go to WB with a fault pending.
  - If ls_done and the timeout coincide, ls_done wins (no fault).
- **BR** (1 cycle)
  - Condition from rd against flags sampled this cycle:
    - 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 !C, 111 never.
  - Taken: pc_load = 1. Not taken: pc_inc = 1.
  - done = 1; return to IDLE.
- **WB** (1 cycle)
  - done = 1 and pc_inc = 1.
  - en[rd] = 1 for fmt 00/01 and for loads; en = 0 for stores and for faults.
  - err = 1 if a fault is pending.
  - Return to IDLE; the counter is cleared.
- **Latency** (accept cycle = N):
  - ALU: done at N+3.
  - Branch: done at N+1.
  - Load/store: done at N+3+k, where k = cycles waited for ls_done.
  - Next instruction can be accepted at the cycle after done.
- **Other rules:**
  - Dropping run mid-instruction does not abort; only further accepts are blocked.
  - ls_done outside LSW is ignored.

Test Plan:
1. fmt 00, rd = 2, rs = 5, op = 3, accepted at N -> en_s at N+1 with mux_sel 0010; en_c at N+2 with mux_sel 0101, sel 011; en = 00000100, done, pc_inc at N+3.
2. fmt 01, imm8 = 0xF0: SIGN_EXT_IMM = 0 -> im_d = 0x00F0; SIGN_EXT_IMM = 1 -> im_d = 0xFFF0; mux_sel = 1000 in EXEC.
3. Load rd = 1, ls_done asserted 4 cycles into LSW -> en_ls = 01 held 4 cycles, en_c only on the ls_done cycle, en = 00000010 next cycle. Store variant -> en_ls = 10, en = 0.
4. LS_TIMEOUT = 3, ls_done never asserted -> en_ls held 3 cycles, then done = 1, err = 1, en = 0. ls_done on exactly the 3rd cycle -> err = 0.
5. Branch cond 001, imm8 = 0xFE: flags zero = 1 -> pc_load = 1, br_off = 0xFFFE. zero = 0 -> pc_inc = 1. done = 1 at N+1 in both cases.
6. REG_COUNT = 4, rd = 6 -> no en_s/en_c, done = 1, err = 1 at N+2. Reset asserted during LSW -> en_ls = 00, inst_ready = 1 the next cycle, no done.
